serial_arith_unit: RTL and testbench
====================================

Name: serial_arith_unit

Overview:
- Parametrised bit-serial arithmetic unit. Operands arrive LSB-first, one bit per accepted cycle, in framed words of WIDTH bits.
- Each word is processed in one of four modes: pass A, two's-complement negate A, A+B, or A-B.
- Emits a registered serial result stream and the assembled parallel word with a signed-overflow flag.
- Successor to the single-mode serial negator; sits between serial link deserialisation logic and word-level consumers.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32
- CW, $clog2(WIDTH), bit-counter width (derived; not overridden)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  a_bit/b_bit/in_start valid this cycle
- in_start  input  1  with in_valid: this bit is bit 0 of a new word
- mode  input  2  sampled only on an accepted start bit; 00 pass, 01 negate, 10 add, 11 sub
- a_bit  input  1  operand A serial bit
- b_bit  input  1  operand B serial bit (ignored in modes 00/01)
- out_valid  output  1  out_bit valid
- out_bit  output  1  result serial bit, LSB-first
- out_done  output  1  one-cycle pulse with the MSB result bit
- out_word  output  WIDTH  assembled result; stable from the out_done cycle until the next out_done
- overflow  output  1  signed overflow of the last completed word; updated with out_done
- busy  output  1  high while a word is in progress (state RUN)

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: state IDLE, bit counter 0, carry 0, out_valid 0, out_bit 0, out_done 0, out_word 0, overflow 0, busy 0. Reset mid-word discards the word; no out_done is produced for it.
- Accepted bit: a cycle with in_valid=1. Cycles with in_valid=0 are stalls; all state holds, and out_valid/out_done are 0 on the following cycle. Gaps of any length are legal.
- States:
  - IDLE: accepted bit with in_start=1 -> RUN, counter=1, mode latched. Accepted bit with in_start=0 is dropped with no output.
  - RUN: accepted bit with in_start=0 -> counter+1. When the accepted bit is bit WIDTH-1 -> IDLE.
  - RUN with in_start=1 on an accepted bit: the current word is aborted (no out_done, out_word/overflow unchanged). This bit is treated as bit 0 of a new word: counter=1, mode re-latched.
- Per-bit arithmetic: sum = x ^ y ^ c, c_next = majority(x, y, c). The carry is initialised on the start bit to cin:
  - pass: x=A, y=0, cin=0
  - negate: x=0, y=~A, cin=1
  - add: x=A, y=B, cin=0
  - sub: x=A, y=~B, cin=1
- On the start bit, the initial carry feeds the sum; it does not use the stale register value.
- Latency: out_bit/out_valid are registered, asserting exactly 1 cycle after the accepted bit they correspond to.
- out_word:
  - Result bits shift into an internal shadow register at index = bit number.
  - On the MSB, the shadow value (including the MSB) is copied to out_word in the same cycle out_done asserts.
  - Bits of an aborted word never reach out_word.
- overflow: carry-into-MSB XOR carry-out-of-MSB, registered with out_done.
  - Always 0 in pass mode.
  - In negate mode, 1 only when A is the most-negative value.
- Word-level result is (x + y + cin) mod 2^WIDTH for every mode.
- Back-to-back words: a start bit on the cycle immediately after an MSB is accepted normally (state is IDLE).

Test Plan:
- WIDTH=8, negate A=0x05, no gaps -> out_bit stream 1,1,0,1,1,1,1,1; out_done on 8th out_valid; out_word=0xFB, overflow=0.
- Negate A=0x80 -> out_word=0x80, overflow=1. Pass A=0x80 -> out_word=0x80, overflow=0.
- Add A=0x7F, B=0x01 -> out_word=0x80, overflow=1. Sub A=0x03, B=0x05 -> out_word=0xFE, overflow=0. Sub A=0x80, B=0x01 -> out_word=0x7F, overflow=1.
- Add 0x12+0x34 with in_valid low for 3 cycles after bit 2 and 1 cycle after bit 6 -> no out_valid during gaps; out_word=0x46; mode held even if the mode pin changes mid-word.
- Start add word, reassert in_start at bit 4 with mode=negate, A=0x01 -> no out_done for the aborted word; next out_done gives out_word=0xFF. Reset at bit 5 of a word -> all outputs 0, busy=0, no out_done.
- WIDTH=4: back-to-back add 0x7+0x1 then sub 0x0-0x1, zero idle cycles -> out_word=0x8 (ovf 1), then 0xF (ovf 0). Non-start bits while IDLE produce no output.

Source files
------------

// File: rtl/serial_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_unit
//  Description : Bit-serial arithmetic unit. LSB-first framed words of WIDTH
//                bits; per-word mode selects pass, negate, add or subtract.
//                Emits a registered serial result, the assembled parallel word
//                and a signed-overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_arith_unit #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic [1:0]       mode,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_done,
  output logic [WIDTH-1:0] out_word,
  output logic             overflow,
  output logic             busy
);

  localparam logic [1:0]    MODE_PASS = 2'b00;
  localparam logic [1:0]    MODE_NEG  = 2'b01;
  localparam logic [1:0]    MODE_ADD  = 2'b10;
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic             carry;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] shadow;

  logic             start_bit;
  logic             run_bit;
  logic             take_bit;
  logic             last_bit;
  logic [1:0]       op_mode;
  logic [CW-1:0]    bit_idx;
  logic             x;
  logic             y;
  logic             cin;
  logic             carry_in;
  logic             sum;
  logic             carry_out;
  logic [WIDTH-1:0] word_final;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Bit classification and next-state: a start bit always (re)opens a word,
  // non-start bits only count while a word is open.
  always_comb begin
    start_bit  = in_valid && in_start;
    run_bit    = in_valid && !in_start && (state == RUN);
    take_bit   = start_bit || run_bit;
    last_bit   = run_bit && (count == LAST_BIT);
    state_next = state;
    if (start_bit)     state_next = RUN;
    else if (last_bit) state_next = IDLE;
  end

  // Full-adder datapath; on the start bit the fresh mode and initial carry
  // are used directly so the stale registered values never leak in.
  always_comb begin
    op_mode  = start_bit ? mode : mode_q;
    bit_idx  = start_bit ? '0 : count;
    x        = a_bit;
    y        = 1'b0;
    cin      = 1'b0;
    case (op_mode)
      MODE_PASS: begin x = a_bit; y = 1'b0;   cin = 1'b0; end
      MODE_NEG:  begin x = 1'b0;  y = ~a_bit; cin = 1'b1; end
      MODE_ADD:  begin x = a_bit; y = b_bit;  cin = 1'b0; end
      default:   begin x = a_bit; y = ~b_bit; cin = 1'b1; end
    endcase
    carry_in   = start_bit ? cin : carry;
    sum        = x ^ y ^ carry_in;
    carry_out  = (x & y) | (x & carry_in) | (y & carry_in);
    word_final = shadow;
    word_final[WIDTH-1] = sum;
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      carry     <= 1'b0;
      mode_q    <= MODE_PASS;
      shadow    <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_done  <= 1'b0;
      out_word  <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= take_bit;
      out_done  <= last_bit;
      if (start_bit) mode_q <= mode;
      if (take_bit) begin
        out_bit         <= sum;
        carry           <= carry_out;
        shadow[bit_idx] <= sum;
        count           <= last_bit ? '0 : bit_idx + CW'(1);
      end
      if (last_bit) begin
        out_word <= word_final;
        overflow <= carry_in ^ carry_out;
      end
    end
  end

  assign busy = (state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_serial_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_arith_unit
//  Description : Scoreboard bench for serial_arith_unit (WIDTH=8 and WIDTH=4)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_arith_unit;

  typedef struct {
    logic        bit_val;
    logic        done;
    logic [31:0] word;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic v8, s8, a8, b8;
  logic [1:0] m8;
  logic ov8, ob8, od8, of8, bz8;
  logic [7:0] ow8;

  logic v4, s4, a4, b4;
  logic [1:0] m4;
  logic ov4, ob4, od4, of4, bz4;
  logic [3:0] ow4;

  exp_t q8[$];
  exp_t q4[$];
  int vectors = 0;
  int miscompares = 0;

  serial_arith_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_start(s8), .mode(m8),
    .a_bit(a8), .b_bit(b8), .out_valid(ov8), .out_bit(ob8), .out_done(od8),
    .out_word(ow8), .overflow(of8), .busy(bz8)
  );

  serial_arith_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_start(s4), .mode(m4),
    .a_bit(a4), .b_bit(b4), .out_valid(ov4), .out_bit(ob4), .out_done(od4),
    .out_word(ow4), .overflow(of4), .busy(bz4)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: signed integer arithmetic on the operand pair
  task automatic model(input int w, input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r, output logic ovf);
    longint mask, half, av, bv, x, y, c, sx, sy, t;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    av = longint'({32'b0, a}) & mask;
    bv = longint'({32'b0, b}) & mask;
    case (m)
      2'd0:    begin x = av; y = 0;          c = 0; end
      2'd1:    begin x = 0;  y = ~av & mask; c = 1; end
      2'd2:    begin x = av; y = bv;         c = 0; end
      default: begin x = av; y = ~bv & mask; c = 1; end
    endcase
    r   = 32'((x + y + c) & mask);
    sx  = (x >= half) ? x - 2 * half : x;
    sy  = (y >= half) ? y - 2 * half : y;
    t   = sx + sy + c;
    ovf = (t > half - 1) || (t < -half);
  endtask

  // Drive one DUT; the other DUT is held without valid input
  task automatic drive(int w, logic v, logic s, logic [1:0] m, logic a, logic b);
    if (w == 8) begin
      v8 = v; s8 = s; m8 = m; a8 = a; b8 = b; v4 = 1'b0;
    end else begin
      v4 = v; s4 = s; m4 = m; a4 = a; b4 = b; v8 = 1'b0;
    end
  endtask

  task automatic idle(int n);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (n) @(posedge clk);
  endtask

  // Send nbits of a word (nbits < w leaves it open / aborted) with optional gaps
  task automatic send_word(input int w, input logic [1:0] m, input logic [31:0] a,
                           input logic [31:0] b, input int nbits,
                           input int g1_at, input int g1_len,
                           input int g2_at, input int g2_len, input bit rgap);
    logic [31:0] r;
    logic ovf;
    exp_t e;
    int gl;
    model(w, m, a, b, r, ovf);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      drive(w, 1'b1, (i == 0), (i == 0) ? m : 2'($urandom), a[i], b[i]);
      e.bit_val = r[i];
      e.done    = (i == w - 1);
      e.word    = r;
      e.ovf     = ovf;
      if (w == 8) q8.push_back(e);
      else        q4.push_back(e);
      @(posedge clk);
      gl = 0;
      if (i == g1_at) gl = g1_len;
      if (i == g2_at) gl = g2_len;
      if (rgap && i != nbits - 1 && $urandom_range(0, 4) == 0) gl = $urandom_range(1, 3);
      for (int j = 0; j < gl; j++) begin
        @(negedge clk);
        drive(w, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
        @(posedge clk);
      end
    end
  endtask

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (ov8) begin
      if (q8.size() == 0) begin
        check("unexpected_out8", 32'(ov8), 32'(0));
      end else begin
        e = q8.pop_front();
        check("bit8", 32'(ob8), 32'(e.bit_val));
        check("done8", 32'(od8), 32'(e.done));
        if (e.done) begin
          check("word8", 32'(ow8), e.word);
          check("ovf8", 32'(of8), 32'(e.ovf));
        end
      end
    end else begin
      check("done_without_valid8", 32'(od8), 32'(0));
    end
  end

  // Monitor for the 4-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (ov4) begin
      if (q4.size() == 0) begin
        check("unexpected_out4", 32'(ov4), 32'(0));
      end else begin
        e = q4.pop_front();
        check("bit4", 32'(ob4), 32'(e.bit_val));
        check("done4", 32'(od4), 32'(e.done));
        if (e.done) begin
          check("word4", 32'(ow4), e.word);
          check("ovf4", 32'(of4), 32'(e.ovf));
        end
      end
    end else begin
      check("done_without_valid4", 32'(od4), 32'(0));
    end
  end

  // Stimulus: directed cases then randomized words
  initial begin
    int nb;
    reset = 1'b1;
    v8 = 0; s8 = 0; m8 = 0; a8 = 0; b8 = 0;
    v4 = 0; s4 = 0; m4 = 0; a4 = 0; b4 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid8", 32'(ov8), 0);
    check("rst_bit8", 32'(ob8), 0);
    check("rst_word8", 32'(ow8), 0);
    check("rst_ovf8", 32'(of8), 0);
    check("rst_busy8", 32'(bz8), 0);
    check("rst_word4", 32'(ow4), 0);
    check("rst_busy4", 32'(bz4), 0);
    reset = 1'b0;

    send_word(8, 2'd1, 32'h05, 32'h00, 8, -1, 0, -1, 0, 1'b0);
    send_word(8, 2'd1, 32'h80, 32'h00, 8, -1, 0, -1, 0, 1'b0);
    send_word(8, 2'd0, 32'h80, 32'h00, 8, -1, 0, -1, 0, 1'b0);
    send_word(8, 2'd2, 32'h7F, 32'h01, 8, -1, 0, -1, 0, 1'b0);
    send_word(8, 2'd3, 32'h03, 32'h05, 8, -1, 0, -1, 0, 1'b0);
    send_word(8, 2'd3, 32'h80, 32'h01, 8, -1, 0, -1, 0, 1'b0);
    idle(2);
    send_word(8, 2'd2, 32'h12, 32'h34, 8, 2, 3, 6, 1, 1'b0);
    idle(1);
    send_word(8, 2'd2, $urandom, $urandom, 4, -1, 0, -1, 0, 1'b0);
    send_word(8, 2'd1, 32'h01, 32'h00, 8, -1, 0, -1, 0, 1'b0);
    idle(1);

    send_word(8, 2'd2, $urandom, $urandom, 5, -1, 0, -1, 0, 1'b0);
    @(negedge clk);
    check("busy_mid_word", 32'(bz8), 1);
    reset = 1'b1;
    drive(8, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(ov8), 0);
    check("midrst_bit", 32'(ob8), 0);
    check("midrst_done", 32'(od8), 0);
    check("midrst_word", 32'(ow8), 0);
    check("midrst_ovf", 32'(of8), 0);
    check("midrst_busy", 32'(bz8), 0);
    reset = 1'b0;
    idle(2);

    send_word(4, 2'd2, 32'h7, 32'h1, 4, -1, 0, -1, 0, 1'b0);
    send_word(4, 2'd3, 32'h0, 32'h1, 4, -1, 0, -1, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(4, 1'b1, 1'b0, 2'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
    end
    idle(2);

    for (int k = 0; k < 150; k++) begin
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 8;
      send_word(8, 2'($urandom), $urandom, $urandom, nb, -1, 0, -1, 0, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    for (int k = 0; k < 80; k++) begin
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4;
      send_word(4, 2'($urandom), $urandom, $urandom, nb, -1, 0, -1, 0, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    check("q8_drained", 32'(q8.size()), 0);
    check("q4_drained", 32'(q4.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
